dip_dvp_timing_gen: RTL and testbench

- Transmit-side DVP source: generates a frame-valid `o_dvp_vs`, a line-valid `o_dvp_hs` and pixel data `o_dvp_data` from a parameterised raster.
- Pulls pixels from an upstream valid/ready stream.
- Used to replay processed ORB/FAST images, or test patterns, into DVP-consuming logic.
- Timing is free-running once a frame starts. The upstream source never stalls the raster; a late pixel is flagged as underflow.

---
 rtl/dip_dvp_timing_gen_if.sv | 31 +++
 rtl/dip_dvp_timing_gen.sv | 143 ++++++++++++++
 tb/tb_dip_dvp_timing_gen.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dip_dvp_timing_gen_if.sv
// Signal bundle between a pixel stream source, the DVP timing generator and a DVP sink.
// master = timing generator side, slave = source/sink side.
interface dip_dvp_timing_gen_if #(
    parameter int DATA_W = 8
);
    // Pixel handshake: a pixel transfers on a rising clock edge where o_pix_ready and
    // i_pix_valid are both high. o_pix_ready never waits on i_pix_valid; a ready cycle
    // without valid data is a missed slot, not a stall.
    logic              i_enable;
    logic [DATA_W-1:0] i_pix_data;
    logic              i_pix_valid;
    logic              o_pix_ready;
    logic              o_dvp_vs;
    logic              o_dvp_hs;
    logic [DATA_W-1:0] o_dvp_data;
    logic              o_frame_start;
    logic              o_frame_done;
    logic              o_underflow;

    modport master (
        input  i_enable, i_pix_data, i_pix_valid,
        output o_pix_ready, o_dvp_vs, o_dvp_hs, o_dvp_data,
        output o_frame_start, o_frame_done, o_underflow
    );

    modport slave (
        output i_enable, i_pix_data, i_pix_valid,
        input  o_pix_ready, o_dvp_vs, o_dvp_hs, o_dvp_data,
        input  o_frame_start, o_frame_done, o_underflow
    );
endinterface

// File: rtl/dip_dvp_timing_gen.sv
// Free-running DVP raster source: walks VFRONT/ACTIVE/VBACK/VGAP phases and pulls one
// pixel per active slot from an upstream stream, flagging missed slots as underflow.
module dip_dvp_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 2,
    parameter int V_BACK   = 2,
    parameter int VS_GAP   = 16,
    parameter int DATA_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dip_dvp_timing_gen_if.master  dvp,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VFRONT = 3'd1,
        ACTIVE = 3'd2,
        VBACK  = 3'd3,
        VGAP   = 3'd4
    } state_t;

    localparam logic [15:0] H_ACT_L      = 16'(H_ACTIVE);
    localparam logic [15:0] H_LAST       = 16'(H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] GAP_LAST     = 16'(VS_GAP - 1);
    localparam logic [15:0] V_FRONT_LAST = 16'(V_FRONT - 1);
    localparam logic [15:0] V_ACT_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] V_BACK_LAST  = 16'(V_BACK - 1);

    state_t            state, state_n;
    logic [15:0]       h_cnt, h_n;
    logic [15:0]       v_cnt, v_n;
    logic [15:0]       line_last;
    logic              line_end;
    logic              pix_ready;
    logic              vs_n;
    logic              vs_q, hs_q, fs_q, fd_q, uf_q;
    logic [DATA_W-1:0] data_q;

    // Falls through any vertical phase configured with zero lines.
    function automatic state_t enter_phase(input state_t s);
        state_t r;
        r = s;
        if (r == VFRONT && V_FRONT == 0) r = ACTIVE;
        if (r == ACTIVE && V_ACTIVE == 0) r = VBACK;
        if (r == VBACK && V_BACK == 0) r = VGAP;
        return r;
    endfunction

    always_comb begin
        line_last = '0;
        case (state)
            VFRONT:  line_last = V_FRONT_LAST;
            ACTIVE:  line_last = V_ACT_LAST;
            VBACK:   line_last = V_BACK_LAST;
            default: line_last = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        h_n      = h_cnt;
        v_n      = v_cnt;
        line_end = (h_cnt == H_LAST);
        case (state)
            IDLE: begin
                if (dvp.i_enable) begin
                    state_n = enter_phase(VFRONT);
                    h_n     = '0;
                    v_n     = '0;
                end
            end
            VFRONT, ACTIVE, VBACK: begin
                h_n = line_end ? 16'd0 : h_cnt + 16'd1;
                if (line_end) begin
                    if (v_cnt == line_last) begin
                        v_n = '0;
                        case (state)
                            VFRONT:  state_n = enter_phase(ACTIVE);
                            ACTIVE:  state_n = enter_phase(VBACK);
                            default: state_n = VGAP;
                        endcase
                    end else begin
                        v_n = v_cnt + 16'd1;
                    end
                end
            end
            VGAP: begin
                // h_cnt doubles as the gap cycle counter; enable is only looked at here and in IDLE.
                if (h_cnt == GAP_LAST) begin
                    h_n     = '0;
                    state_n = dvp.i_enable ? enter_phase(VFRONT) : IDLE;
                end else begin
                    h_n = h_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign pix_ready = (state == ACTIVE) && (h_cnt < H_ACT_L);
    assign vs_n      = (state == VFRONT) || (state == ACTIVE) || (state == VBACK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            h_cnt  <= '0;
            v_cnt  <= '0;
            vs_q   <= 1'b0;
            hs_q   <= 1'b0;
            data_q <= '0;
            fs_q   <= 1'b0;
            fd_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            state  <= state_n;
            h_cnt  <= h_n;
            v_cnt  <= v_n;
            vs_q   <= vs_n;
            hs_q   <= pix_ready;
            data_q <= (pix_ready && dvp.i_pix_valid) ? dvp.i_pix_data : '0;
            fs_q   <= vs_n && !vs_q;
            fd_q   <= !vs_n && vs_q;
            // Frame start wins; the two can never coincide with a pixel slot anyway.
            if (vs_n && !vs_q) begin
                uf_q <= 1'b0;
            end else if (pix_ready && !dvp.i_pix_valid) begin
                uf_q <= 1'b1;
            end
        end
    end

    assign dvp.o_pix_ready   = pix_ready;
    assign dvp.o_dvp_vs      = vs_q;
    assign dvp.o_dvp_hs      = hs_q;
    assign dvp.o_dvp_data    = data_q;
    assign dvp.o_frame_start = fs_q;
    assign dvp.o_frame_done  = fd_q;
    assign dvp.o_underflow   = uf_q;
    assign dbg_state         = state;
endmodule

// File: tb/tb_dip_dvp_timing_gen.sv
// Bench for dip_dvp_timing_gen on a small 4x3 raster: pixel scoreboard, raster timing
// monitor with a DVP line/pixel counter model, and directed frame scenarios.
module tb_dip_dvp_timing_gen;
    localparam int H_ACTIVE = 4;
    localparam int H_BLANK  = 3;
    localparam int V_ACTIVE = 3;
    localparam int V_FRONT  = 1;
    localparam int V_BACK   = 1;
    localparam int VS_GAP   = 5;
    localparam int DATA_W   = 8;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    dip_dvp_timing_gen_if #(.DATA_W(DATA_W)) dvp ();

    dip_dvp_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .V_FRONT(V_FRONT), .V_BACK(V_BACK), .VS_GAP(VS_GAP), .DATA_W(DATA_W)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .dvp(dvp),
        .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 1; i <= 12; i++) exp_q.push_back(DATA_W'(i));
    endtask

    // Pixel source: counts 1,2,3... per frame, withholds valid on slot drop_slot.
    int   src_data = 1;
    int   slot = 0;
    int   drop_slot = -1;
    logic take, seen;
    initial begin
        dvp.i_pix_valid = 1'b0;
        dvp.i_pix_data  = '0;
        forever begin
            @(negedge clk);
            if (dvp.o_frame_start) begin
                src_data = 1;
                slot     = 0;
            end
            dvp.i_pix_valid = (slot != drop_slot);
            dvp.i_pix_data  = DATA_W'(src_data);
            seen = dvp.o_pix_ready;
            take = seen & dvp.i_pix_valid;
            @(posedge clk);
            #1;
            if (take) src_data++;
            if (seen) slot++;
        end
    end

    // Monitor: raster timing, DVP counter model and pixel scoreboard.
    int   cyc = 0;
    logic prev_vs = 1'b0, prev_hs = 1'b0, prev_uf = 1'b0;
    bit   seen_rise = 0, seen_fall = 0;
    int   vs_rise_cyc, vs_fall_cyc, last_hs_rise;
    int   n_vs_rise = 0, n_vs_fall = 0, fs_cnt = 0, fd_cnt = 0;
    int   vs_high_len, gap_len, period, first_hs_delay;
    int   hs_run = 0, hs_in_frame = 0, lb_peak = 0, lb_lines_at_fall;
    int   uf_rise_off, uf_at_fall, uf_pre_rise, uf_at_rise, fs_at_rise, fd_at_fall, uf_any;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            seen_rise = 0;
            seen_fall = 0;
            prev_vs   = 1'b0;
            prev_hs   = 1'b0;
            prev_uf   = 1'b0;
            hs_run    = 0;
        end else begin
            if (dvp.o_frame_start) fs_cnt++;
            if (dvp.o_frame_done) fd_cnt++;
            if (dvp.o_dvp_vs && !prev_vs) begin
                if (seen_fall) gap_len = cyc - vs_fall_cyc;
                if (seen_rise) period = cyc - vs_rise_cyc;
                vs_rise_cyc = cyc;
                seen_rise   = 1;
                n_vs_rise++;
                hs_in_frame = 0;
                lb_peak     = 0;
                uf_any      = 0;
                uf_pre_rise = int'(prev_uf);
                uf_at_rise  = int'(dvp.o_underflow);
                fs_at_rise  = int'(dvp.o_frame_start);
            end
            if (!dvp.o_dvp_vs && prev_vs) begin
                vs_high_len      = cyc - vs_rise_cyc;
                lb_lines_at_fall = hs_in_frame;
                vs_fall_cyc      = cyc;
                seen_fall        = 1;
                n_vs_fall++;
                uf_at_fall = int'(dvp.o_underflow);
                fd_at_fall = int'(dvp.o_frame_done);
            end
            if (dvp.o_dvp_hs && !prev_hs) begin
                if (hs_in_frame == 0) first_hs_delay = cyc - vs_rise_cyc;
                else check("hs_spacing", cyc - last_hs_rise, H_TOTAL);
                last_hs_rise = cyc;
            end
            if (dvp.o_dvp_hs) begin
                hs_run++;
                if (hs_run > lb_peak) lb_peak = hs_run;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pixel_extra: got %0d, expected no pixel", dvp.o_dvp_data);
                end else begin
                    check("pixel_data", int'(dvp.o_dvp_data), int'(exp_q.pop_front()));
                end
            end else if (prev_hs) begin
                check("hs_width", hs_run, H_ACTIVE);
                hs_in_frame++;
                hs_run = 0;
            end
            if (dvp.o_underflow && !prev_uf) uf_rise_off = cyc - vs_rise_cyc;
            if (dvp.o_underflow) uf_any = 1;
            prev_vs = dvp.o_dvp_vs;
            prev_hs = dvp.o_dvp_hs;
            prev_uf = dvp.o_underflow;
        end
    end

    task automatic wait_rise(input int budget);
        int start;
        int k;
        start = n_vs_rise;
        k = 0;
        while (n_vs_rise == start && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_vs_rise == start) begin
            n_tests++;
            n_fail++;
            $display("FAIL vs_rise_timeout: no vs rise within %0d cycles", budget);
        end
    endtask

    task automatic wait_fall(input int budget);
        int start;
        int k;
        start = n_vs_fall;
        k = 0;
        while (n_vs_fall == start && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (n_vs_fall == start) begin
            n_tests++;
            n_fail++;
            $display("FAIL vs_fall_timeout: no vs fall within %0d cycles", budget);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vs"}, int'(dvp.o_dvp_vs), 0);
        check({tag, "_hs"}, int'(dvp.o_dvp_hs), 0);
        check({tag, "_data"}, int'(dvp.o_dvp_data), 0);
        check({tag, "_ready"}, int'(dvp.o_pix_ready), 0);
        check({tag, "_fs"}, int'(dvp.o_frame_start), 0);
        check({tag, "_fd"}, int'(dvp.o_frame_done), 0);
        check({tag, "_uf"}, int'(dvp.o_underflow), 0);
        check({tag, "_state"}, int'(dbg_state), 0);
    endtask

    int uf_seq[12] = '{1, 2, 3, 4, 5, 0, 6, 7, 8, 9, 10, 11};
    int saved_rise;

    initial begin
        rst_n        = 1'b0;
        dvp.i_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");

        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("idle_no_enable_state", int'(dbg_state), 0);
        check("idle_no_enable_vs", int'(dvp.o_dvp_vs), 0);

        // Basic frame
        push_frame();
        dvp.i_enable = 1'b1;
        @(posedge clk);
        #1;
        check("start_state", int'(dbg_state), 1);
        check("start_vs_edge1", int'(dvp.o_dvp_vs), 0);
        @(posedge clk);
        #1;
        check("start_vs_edge2", int'(dvp.o_dvp_vs), 1);
        check("start_fs_edge2", int'(dvp.o_frame_start), 1);
        wait_fall(100);
        check("f1_vs_high", vs_high_len, 35);
        check("f1_first_hs", first_hs_delay, 7);
        check("f1_lines", lb_lines_at_fall, 3);
        check("f1_lb_peak", lb_peak, 4);
        check("f1_fs_count", fs_cnt, 1);
        check("f1_fd_count", fd_cnt, 1);
        check("f1_fd_at_fall", fd_at_fall, 1);
        check("f1_underflow", uf_any, 0);
        check("f1_pixels_left", exp_q.size(), 0);

        // Continuous frames
        push_frame();
        wait_rise(100);
        check("f2_gap", gap_len, 5);
        check("f2_period", period, 40);
        wait_rise(100);
        check("f3_period", period, 40);

        // Underflow on the 2nd pixel of line 2
        foreach (uf_seq[i]) exp_q.push_back(DATA_W'(uf_seq[i]));
        drop_slot = 5;
        wait_fall(100);
        check("f3_lines", lb_lines_at_fall, 3);
        check("f3_uf_rise_offset", uf_rise_off, 15);
        check("f3_uf_at_fall", uf_at_fall, 1);
        check("f3_pixels_left", exp_q.size(), 0);
        drop_slot = -1;
        push_frame();
        wait_rise(100);
        check("f4_uf_before_start", uf_pre_rise, 1);
        check("f4_uf_at_start", uf_at_rise, 0);
        check("f4_fs_at_rise", fs_at_rise, 1);

        // Enable dropped mid-ACTIVE
        repeat (10) @(posedge clk);
        dvp.i_enable = 1'b0;
        wait_fall(100);
        check("f4_lines", lb_lines_at_fall, 3);
        check("f4_fd_at_fall", fd_at_fall, 1);
        check("f4_fd_count", fd_cnt, 4);
        check("f4_pixels_left", exp_q.size(), 0);
        check("gap_state_a", int'(dbg_state), 4);
        repeat (2) @(posedge clk);
        #1;
        check("gap_state_b", int'(dbg_state), 4);
        @(posedge clk);
        #1;
        check("after_gap_idle", int'(dbg_state), 0);
        saved_rise = n_vs_rise;
        repeat (60) @(posedge clk);
        #1;
        check("no_new_frame", n_vs_rise, saved_rise);
        check("idle_vs_low", int'(dvp.o_dvp_vs), 0);

        // Reset during line 2
        push_frame();
        dvp.i_enable = 1'b1;
        wait_rise(100);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        push_frame();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_state", int'(dbg_state), 1);
        check("restart_vs_edge1", int'(dvp.o_dvp_vs), 0);
        @(posedge clk);
        #1;
        check("restart_vs_edge2", int'(dvp.o_dvp_vs), 1);
        check("restart_fs_edge2", int'(dvp.o_frame_start), 1);
        wait_fall(100);
        check("f5_vs_high", vs_high_len, 35);
        check("f5_lines", lb_lines_at_fall, 3);
        check("f5_lb_peak", lb_peak, 4);
        check("f5_pixels_left", exp_q.size(), 0);

        dvp.i_enable = 1'b0;
        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
